regfile_wb_arbiter: RTL and testbench

- Producer-side counterpart to the register file write port: the single block that drives rd_wen/rd_addr/rd_data.
- Merges two writeback sources:
  - the in-order pipeline writeback stage, which has priority and no backpressure;
  - a long-latency result channel (mul/div/load-miss) with valid/ready, buffered in a small FIFO.
- Exports a per-register pending mask so the hazard unit can stall dependants of outstanding long-latency writes.

---
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: single producer for the register file write port.
// Merges the in-order pipeline writeback (priority, no backpressure) with a
// long-latency result channel (valid/ready) buffered in a DEPTH-entry FIFO.
// Ports:
//   clk, reset_n                     clock (posedge), async active-low reset
//   pipe_wen/pipe_addr/pipe_data     pipeline writeback request
//   lr_valid/lr_ready/lr_addr/lr_data long-latency result channel
//   pipe_stall                       pipeline holds its writeback stage this cycle
//   lr_pending                       bit i = FIFO holds a write to xi
//   fifo_count                       occupied FIFO entries
//   rd_wen/rd_addr/rd_data           registered register file write port
`ifndef XLEN
`define XLEN 32
`endif
module regfile_wb_arbiter #(
  parameter int XLEN = `XLEN,
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pipe_wen,
  input  logic [4:0]                 pipe_addr,
  input  logic [XLEN-1:0]            pipe_data,
  input  logic                       lr_valid,
  output logic                       lr_ready,
  input  logic [4:0]                 lr_addr,
  input  logic [XLEN-1:0]            lr_data,
  output logic                       pipe_stall,
  output logic [31:0]                lr_pending,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       rd_wen,
  output logic [4:0]                 rd_addr,
  output logic [XLEN-1:0]            rd_data
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [4:0]      mem_addr [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [SW-1:0]   starve, starve_n;
  logic [31:0]     pend_n;
  logic            pipe_req, enq, deq;
  assign lr_ready = fifo_count != CW'(DEPTH);
  always_comb begin
    pipe_req = pipe_wen && pipe_addr != 5'd0 && !pipe_stall;
    enq = lr_valid && lr_ready && lr_addr != 5'd0;
    // Only entries already stored can be granted, so there is no enqueue bypass.
    deq = !pipe_req && fifo_count != '0;
    // A non-empty FIFO that is not popped can only have lost to the pipeline.
    starve_n = (fifo_count == '0 || deq) ? '0 :
               (starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
    // Set is applied after clear so an enqueue wins over a same-bit pop.
    pend_n = (lr_pending & ~(deq ? 32'd1 << mem_addr[rptr] : 32'd0)) |
             (enq ? 32'd1 << lr_addr : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wptr] <= lr_addr;
      mem_data[wptr] <= lr_data;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      starve <= '0;
      pipe_stall <= 1'b0;
      lr_pending <= '0;
      rd_wen <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      wptr <= enq ? wptr + 1'b1 : wptr;
      rptr <= deq ? rptr + 1'b1 : rptr;
      fifo_count <= fifo_count + CW'(enq) - CW'(deq);
      starve <= starve_n;
      // Stall lands in the cycle the counter holds STARVE_LIMIT, forcing a pop.
      pipe_stall <= starve_n == SW'(STARVE_LIMIT);
      lr_pending <= pend_n;
      rd_wen <= pipe_req || deq;
      if (pipe_req) begin
        rd_addr <= pipe_addr;
        rd_data <= pipe_data;
      end else if (deq) begin
        rd_addr <= mem_addr[rptr];
        rd_data <= mem_data[rptr];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pipe_wen = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        lr_valid = 1'b0;
  logic        lr_ready;
  logic [4:0]  lr_addr = '0;
  logic [31:0] lr_data = '0;
  logic        pipe_stall;
  logic [31:0] lr_pending;
  logic [2:0]  fifo_count;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_wen(pipe_wen), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_addr(lr_addr), .lr_data(lr_data),
    .pipe_stall(pipe_stall), .lr_pending(lr_pending), .fifo_count(fifo_count),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, 64'(rd_wen), 64'd1);
    chk({tag, "_addr"}, 64'(rd_addr), 64'(a));
    chk({tag, "_data"}, 64'(rd_data), 64'(d));
  endtask

  initial begin
    #2;
    chk("rst_wen", 64'(rd_wen), 64'd0);
    chk("rst_addr", 64'(rd_addr), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_pend", 64'(lr_pending), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(lr_ready), 64'd1);
    step();
    reset_n = 1'b1;
    step();

    // pipeline only
    pipe_wen = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hA5A5_0001;
    step();
    pipe_wen = 1'b0;
    wr("pipe", 5'd5, 32'hA5A5_0001);
    step();
    chk("pipe_idle_wen", 64'(rd_wen), 64'd0);
    chk("pipe_hold_addr", 64'(rd_addr), 64'd5);

    // long-latency drain: pending visible, no bypass, write two cycles later
    lr_valid = 1'b1; lr_addr = 5'd7; lr_data = 32'h1234;
    step();
    lr_valid = 1'b0;
    chk("lr_pend_set", 64'(lr_pending[7]), 64'd1);
    chk("lr_count1", 64'(fifo_count), 64'd1);
    chk("lr_no_bypass", 64'(rd_wen), 64'd0);
    step();
    wr("lr", 5'd7, 32'h1234);
    chk("lr_pend_clr", 64'(lr_pending), 64'd0);
    chk("lr_count0", 64'(fifo_count), 64'd0);

    // fill under a busy pipeline, then drain in order
    for (int i = 1; i <= 4; i++) begin
      pipe_wen = 1'b1; pipe_addr = 5'(10 + i); pipe_data = 32'(i);
      lr_valid = 1'b1; lr_addr = 5'(i); lr_data = 32'(16'hD000 + i);
      step();
      wr("fill_pipe", 5'(10 + i), 32'(i));
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ready", 64'(lr_ready), 64'd0);
    lr_addr = 5'd5; lr_data = 32'hDEAD;
    pipe_addr = 5'd15; pipe_data = 32'h15;
    step();
    chk("full_count_hold", 64'(fifo_count), 64'd4);
    chk("full_pend", 64'(lr_pending), 64'h1E);
    pipe_wen = 1'b0; lr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      wr("drain", 5'(i), 32'(16'hD000 + i));
      if (i == 1) chk("drain_ready", 64'(lr_ready), 64'd1);
    end
    step();
    chk("drain_done_wen", 64'(rd_wen), 64'd0);
    chk("drain_pend", 64'(lr_pending), 64'd0);

    // starvation: FIFO holds x9 while the pipeline writes every cycle
    lr_valid = 1'b1; lr_addr = 5'd9; lr_data = 32'h99;
    pipe_wen = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h100;
    step();
    lr_valid = 1'b0;
    chk("starve_stall0", 64'(pipe_stall), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      pipe_data = 32'(32'h100 + i);
      step();
      wr("starve_pipe", 5'd3, 32'(32'h100 + i));
      chk("starve_stall", 64'(pipe_stall), 64'(i == 8));
    end
    pipe_data = 32'hBEEF;
    step();
    wr("starve_lr", 5'd9, 32'h99);
    chk("starve_stall_end", 64'(pipe_stall), 64'd0);
    step();
    wr("starve_held", 5'd3, 32'hBEEF);
    pipe_wen = 1'b0;
    step();
    chk("starve_idle", 64'(rd_wen), 64'd0);

    // x0 on both sources
    pipe_wen = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hFFFF;
    lr_valid = 1'b1; lr_addr = 5'd0; lr_data = 32'hEEEE;
    chk("x0_ready", 64'(lr_ready), 64'd1);
    step();
    pipe_wen = 1'b0; lr_valid = 1'b0;
    chk("x0_wen", 64'(rd_wen), 64'd0);
    chk("x0_count", 64'(fifo_count), 64'd0);
    chk("x0_pend", 64'(lr_pending), 64'd0);
    step();
    chk("x0_wen2", 64'(rd_wen), 64'd0);

    // reset mid-operation with 3 queued entries
    for (int i = 0; i < 3; i++) begin
      pipe_wen = 1'b1; pipe_addr = 5'd2; pipe_data = 32'(i);
      lr_valid = 1'b1; lr_addr = 5'(11 + i); lr_data = 32'(i);
      step();
    end
    chk("mid_count3", 64'(fifo_count), 64'd3);
    pipe_wen = 1'b0; lr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_pend", 64'(lr_pending), 64'd0);
    chk("mid_wen", 64'(rd_wen), 64'd0);
    chk("mid_ready", 64'(lr_ready), 64'd1);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_write", 64'(rd_wen), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
